// File: rtl/ysyx_22040759_axi_arbiter.sv
// ysyx_22040759_axi_arbiter
// Shares the core's single AXI read/write master between the instruction-fetch
// port (read only) and the load/store port (read or write). One transaction is
// outstanding at a time: the winner's request is latched and forwarded to the
// bridge, and the bridge's answer is steered back to the owning port as a
// one-cycle ready pulse. A watchdog ends a transaction the bridge never answers
// with SLVERR after TIMEOUT cycles of rw_valid.
//
// Build option: define YSYX_22040759_ARB_RR_EN for round-robin tie breaking.
// Without it, MEM has fixed priority over IF.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; requests sampled, winner latched on grant
// BUSY  | rw_valid high with the latched request, watchdog running
// RESP  | ready pulse with the latched response on the owner's port

module ysyx_22040759_axi_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_valid,
    input  logic [63:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_ready,
    output logic [63:0] if_data_read,
    output logic [1:0]  if_resp,

    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [63:0] mem_data_write,
    output logic        mem_ready,
    output logic [63:0] mem_data_read,
    output logic [1:0]  mem_resp,

    output logic        rw_valid,
    output logic        rw_req,
    output logic [63:0] rw_addr,
    output logic [1:0]  rw_size,
    output logic [63:0] rw_data_write,
    input  logic        rw_ready,
    input  logic [63:0] rw_data_read,
    input  logic [1:0]  rw_resp
);

    localparam int unsigned     WD_W        = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT - 1);
    localparam logic            OWNER_IF    = 1'b0;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              rw_valid_q, rw_valid_d;
    logic              rw_req_q, rw_req_d;
    logic [63:0]       rw_addr_q, rw_addr_d;
    logic [1:0]        rw_size_q, rw_size_d;
    logic [63:0]       rw_data_write_q, rw_data_write_d;

    logic              if_ready_q, if_ready_d;
    logic [63:0]       if_data_read_q, if_data_read_d;
    logic [1:0]        if_resp_q, if_resp_d;
    logic              mem_ready_q, mem_ready_d;
    logic [63:0]       mem_data_read_q, mem_data_read_d;
    logic [1:0]        mem_resp_q, mem_resp_d;

    logic              any_req;
    logic              grant_mem;
    logic              done;
    logic [63:0]       rsp_data;
    logic [1:0]        rsp_resp;

    assign any_req = if_valid | mem_valid;

    // Winner selection among the requests present in IDLE.
    always_comb begin
        grant_mem = mem_valid;
        if (mem_valid && if_valid) begin
`ifdef YSYX_22040759_ARB_RR_EN
            grant_mem = (last_q == OWNER_IF);
`else
            grant_mem = 1'b1;
`endif
        end
    end

    // A real response in the watchdog's last cycle takes precedence over SLVERR.
    always_comb begin
        done     = (state_q == ST_BUSY) && (rw_ready || (wd_q == WD_LAST));
        rsp_data = rw_data_read;
        rsp_resp = rw_resp;
        if (!rw_ready) begin
            rsp_data = '0;
            rsp_resp = RESP_SLVERR;
        end
    end

    // Next state, request latch and registered port outputs.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        wd_d            = wd_q;

        rw_valid_d      = 1'b0;
        rw_req_d        = rw_req_q;
        rw_addr_d       = rw_addr_q;
        rw_size_d       = rw_size_q;
        rw_data_write_d = rw_data_write_q;

        if_ready_d      = 1'b0;
        if_data_read_d  = '0;
        if_resp_d       = '0;
        mem_ready_d     = 1'b0;
        mem_data_read_d = '0;
        mem_resp_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_BUSY;
                    owner_d    = grant_mem;
                    last_d     = grant_mem;
                    wd_d       = '0;
                    rw_valid_d = 1'b1;
                    if (grant_mem) begin
                        rw_req_d        = mem_req;
                        rw_addr_d       = mem_addr;
                        rw_size_d       = mem_size;
                        rw_data_write_d = mem_data_write;
                    end else begin
                        rw_req_d        = 1'b0;
                        rw_addr_d       = if_addr;
                        rw_size_d       = if_size;
                        rw_data_write_d = '0;
                    end
                end
            end

            ST_BUSY: begin
                if (done) begin
                    state_d = ST_RESP;
                    if (owner_q == OWNER_IF) begin
                        if_ready_d     = 1'b1;
                        if_data_read_d = rsp_data;
                        if_resp_d      = rsp_resp;
                    end else begin
                        mem_ready_d     = 1'b1;
                        mem_data_read_d = rsp_data;
                        mem_resp_d      = rsp_resp;
                    end
                end else begin
                    // wd stops at WD_LAST because BUSY always exits there.
                    rw_valid_d = 1'b1;
                    wd_d       = wd_q + WD_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs; reset drops any in-flight transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWNER_IF;
            last_q          <= OWNER_IF;
            wd_q            <= '0;
            rw_valid_q      <= 1'b0;
            rw_req_q        <= 1'b0;
            rw_addr_q       <= '0;
            rw_size_q       <= '0;
            rw_data_write_q <= '0;
            if_ready_q      <= 1'b0;
            if_data_read_q  <= '0;
            if_resp_q       <= '0;
            mem_ready_q     <= 1'b0;
            mem_data_read_q <= '0;
            mem_resp_q      <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            wd_q            <= wd_d;
            rw_valid_q      <= rw_valid_d;
            rw_req_q        <= rw_req_d;
            rw_addr_q       <= rw_addr_d;
            rw_size_q       <= rw_size_d;
            rw_data_write_q <= rw_data_write_d;
            if_ready_q      <= if_ready_d;
            if_data_read_q  <= if_data_read_d;
            if_resp_q       <= if_resp_d;
            mem_ready_q     <= mem_ready_d;
            mem_data_read_q <= mem_data_read_d;
            mem_resp_q      <= mem_resp_d;
        end
    end

    assign rw_valid      = rw_valid_q;
    assign rw_req        = rw_req_q;
    assign rw_addr       = rw_addr_q;
    assign rw_size       = rw_size_q;
    assign rw_data_write = rw_data_write_q;

    assign if_ready      = if_ready_q;
    assign if_data_read  = if_data_read_q;
    assign if_resp       = if_resp_q;
    assign mem_ready     = mem_ready_q;
    assign mem_data_read = mem_data_read_q;
    assign mem_resp      = mem_resp_q;

endmodule

// File: tb/tb_ysyx_22040759_axi_arbiter.sv
// Bench for ysyx_22040759_axi_arbiter: directed scenarios with literal
// expectations, then randomized requesters and bridge, all cross-checked every
// cycle against a transaction-level model of the arbiter.

module tb_ysyx_22040759_axi_arbiter;

    localparam int unsigned TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic [63:0] if_addr = '0;
    logic [1:0]  if_size = '0;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic [1:0]  if_resp;
    logic        mem_valid = 1'b0;
    logic        mem_req = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [1:0]  mem_size = '0;
    logic [63:0] mem_data_write = '0;
    logic        mem_ready;
    logic [63:0] mem_data_read;
    logic [1:0]  mem_resp;
    logic        rw_valid;
    logic        rw_req;
    logic [63:0] rw_addr;
    logic [1:0]  rw_size;
    logic [63:0] rw_data_write;
    logic        rw_ready = 1'b0;
    logic [63:0] rw_data_read = '0;
    logic [1:0]  rw_resp = '0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ysyx_22040759_axi_arbiter #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
        .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_data_write(mem_data_write),
        .mem_ready(mem_ready), .mem_data_read(mem_data_read), .mem_resp(mem_resp),
        .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr),
        .rw_size(rw_size), .rw_data_write(rw_data_write),
        .rw_ready(rw_ready), .rw_data_read(rw_data_read), .rw_resp(rw_resp)
    );

    always #5 clock = ~clock;

    // Transaction-level model: a granted transaction, how many cycles the
    // bridge has seen it, and a completion to be shown for one cycle.
    bit          m_busy, m_ans, m_owner, m_last;   // owner/last: 1 = MEM
    int          m_age;
    logic        m_req;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size, m_rresp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_ans = 0; m_owner = 0; m_last = 0; m_age = 0;
        m_req = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_size = '0; m_rresp = '0;
    endtask

    task automatic model_step();
        bit take_mem;
        if (m_ans) begin
            m_ans = 0;
        end else if (m_busy) begin
            m_age++;
            if (rw_ready) begin
                m_busy = 0; m_ans = 1; m_rdata = rw_data_read; m_rresp = rw_resp;
            end else if (m_age == int'(TMO)) begin
                m_busy = 0; m_ans = 1; m_rdata = '0; m_rresp = 2'b10;
            end
        end else if (if_valid || mem_valid) begin
            if (if_valid && mem_valid) begin
`ifdef YSYX_22040759_ARB_RR_EN
                take_mem = !m_last;
`else
                take_mem = 1;
`endif
            end else begin
                take_mem = mem_valid;
            end
            m_busy = 1; m_age = 0; m_owner = take_mem; m_last = take_mem;
            m_req   = take_mem ? mem_req        : 1'b0;
            m_addr  = take_mem ? mem_addr       : if_addr;
            m_size  = take_mem ? mem_size       : if_size;
            m_wdata = take_mem ? mem_data_write : 64'd0;
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_clear();
        else        model_step();
    end

    task automatic compare_all();
        bit e_if, e_mem;
        e_if  = m_ans && !m_owner;
        e_mem = m_ans && m_owner;
        check("rw_valid", 64'(rw_valid), 64'(m_busy));
        if (m_busy) begin
            check("rw_req", 64'(rw_req), 64'(m_req));
            check("rw_addr", rw_addr, m_addr);
            check("rw_size", 64'(rw_size), 64'(m_size));
            check("rw_data_write", rw_data_write, m_wdata);
        end
        check("if_ready", 64'(if_ready), 64'(e_if));
        check("mem_ready", 64'(mem_ready), 64'(e_mem));
        if (e_if) begin
            check("if_data_read", if_data_read, m_rdata);
            check("if_resp", 64'(if_resp), 64'(m_rresp));
        end
        if (e_mem) begin
            check("mem_data_read", mem_data_read, m_rdata);
            check("mem_resp", 64'(mem_resp), 64'(m_rresp));
        end
    endtask

    always @(negedge clock) if (chk_en) compare_all();

    // One cycle; requesters drop valid on the edge after they see ready.
    task automatic tick();
        @(negedge clock);
        if (if_ready)  if_valid  = 1'b0;
        if (mem_ready) mem_valid = 1'b0;
    endtask

    // Wait for a grant, answer it in its lat-th rw_valid cycle.
    task automatic bridge_answer(input int lat, input logic [63:0] d, input logic [1:0] r,
                                 output logic [63:0] addr_seen);
        int guard;
        guard = 0;
        addr_seen = '0;
        while (rw_valid !== 1'b1 && guard < 30) begin
            tick();
            guard++;
        end
        if (rw_valid !== 1'b1) begin
            check("grant_wait", 64'(rw_valid), 64'd1);
            return;
        end
        addr_seen = rw_addr;
        repeat (lat - 1) tick();
        rw_data_read = d; rw_resp = r; rw_ready = 1'b1;
        tick();
        rw_ready = 1'b0;
    endtask

    task automatic idle_gap();
        repeat (3) tick();
    endtask

    logic [63:0] a1, a2;
    int cnt;

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_rw_valid", 64'(rw_valid), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_rw_addr", rw_addr, 64'd0);
        check("rst_if_data", if_data_read, 64'd0);
        check("rst_mem_resp", 64'(mem_resp), 64'd0);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single fetch answered in cycle 4.
        if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'd2;
        tick();
        check("fetch_rw_valid_c1", 64'(rw_valid), 64'd1);
        check("fetch_rw_req_c1", 64'(rw_req), 64'd0);
        check("fetch_rw_addr_c1", rw_addr, 64'h8000_0000);
        tick(); tick(); tick();
        check("fetch_rw_valid_c4", 64'(rw_valid), 64'd1);
        rw_ready = 1'b1; rw_data_read = 64'h13; rw_resp = 2'b00;
        tick();
        rw_ready = 1'b0;
        check("fetch_if_ready_c5", 64'(if_ready), 64'd1);
        check("fetch_if_data_c5", if_data_read, 64'h13);
        check("fetch_mem_ready_c5", 64'(mem_ready), 64'd0);
        check("fetch_rw_valid_c5", 64'(rw_valid), 64'd0);
        tick();
        check("fetch_if_ready_c6", 64'(if_ready), 64'd0);
        idle_gap();

        // Store.
        mem_valid = 1'b1; mem_req = 1'b1; mem_addr = 64'h8000_1000;
        mem_data_write = 64'hDEAD_BEEF; mem_size = 2'd3;
        tick();
        check("store_rw_req", 64'(rw_req), 64'd1);
        check("store_rw_wdata", rw_data_write, 64'hDEAD_BEEF);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rw_ready = (i == 1); rw_data_read = 64'h0; rw_resp = 2'b00;
            tick();
            if (mem_ready) cnt++;
        end
        rw_ready = 1'b0;
        check("store_ready_pulses", 64'(cnt), 64'd1);
        idle_gap();

        // Contention: MEM first on a tie after reset, IF next.
        if_valid = 1'b1; if_addr = 64'h1000; mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 64'h2000;
        bridge_answer(2, 64'h11, 2'b00, a1);
        bridge_answer(2, 64'h22, 2'b00, a2);
        check("tie1_first", a1, 64'h2000);
        check("tie1_second", a2, 64'h1000);
        idle_gap();
        // MEM alone makes MEM the last owner; the next tie shows the policy.
        mem_valid = 1'b1; mem_addr = 64'h3000;
        bridge_answer(2, 64'h33, 2'b00, a1);
        idle_gap();
        if_valid = 1'b1; if_addr = 64'h4000; mem_valid = 1'b1; mem_addr = 64'h5000;
        bridge_answer(2, 64'h44, 2'b00, a1);
        bridge_answer(2, 64'h55, 2'b00, a2);
`ifdef YSYX_22040759_ARB_RR_EN
        check("tie2_first", a1, 64'h4000);
        check("tie2_second", a2, 64'h5000);
`else
        check("tie2_first", a1, 64'h5000);
        check("tie2_second", a2, 64'h4000);
`endif
        idle_gap();

        // Watchdog: rw_valid high for TMO cycles, then SLVERR.
        if_valid = 1'b1; if_addr = 64'h6000;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if_ready) break;
            if (rw_valid) cnt++;
        end
        check("tmo_valid_cycles", 64'(cnt), 64'(TMO));
        check("tmo_if_ready", 64'(if_ready), 64'd1);
        check("tmo_if_resp", 64'(if_resp), 64'h2);
        check("tmo_if_data", if_data_read, 64'd0);
        tick();
        rw_ready = 1'b1; rw_data_read = 64'h99; rw_resp = 2'b00;
        tick();
        rw_ready = 1'b0;
        tick();
        check("late_rsp_if_ready", 64'(if_ready), 64'd0);
        check("late_rsp_mem_ready", 64'(mem_ready), 64'd0);
        idle_gap();

        // Response in the watchdog's last cycle wins.
        mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 64'h7000;
        bridge_answer(int'(TMO), 64'h55, 2'b01, a1);
        check("edge_mem_resp", 64'(mem_resp), 64'h1);
        check("edge_mem_data", mem_data_read, 64'h55);
        idle_gap();

        // Error response passes through.
        mem_valid = 1'b1; mem_addr = 64'h7100;
        bridge_answer(1, 64'hABCD, 2'b11, a1);
        check("err_mem_ready", 64'(mem_ready), 64'd1);
        check("err_mem_resp", 64'(mem_resp), 64'h3);
        idle_gap();

        // Reset during BUSY; the still-pending fetch is granted again.
        if_valid = 1'b1; if_addr = 64'h8800;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("rstbusy_rw_valid", 64'(rw_valid), 64'd0);
        check("rstbusy_rw_addr", rw_addr, 64'd0);
        check("rstbusy_if_ready", 64'(if_ready), 64'd0);
        tick(); tick();
        #2 reset = 1'b1;
        tick();
        check("regrant_rw_valid", 64'(rw_valid), 64'd1);
        bridge_answer(1, 64'h77, 2'b00, a1);
        check("regrant_addr", a1, 64'h8800);
        check("regrant_if_data", if_data_read, 64'h77);
        idle_gap();

        // Randomized requesters and bridge.
        begin
            bit armed;
            int lat, r;
            armed = 0; lat = 0;
            for (int c = 0; c < 4000; c++) begin
                tick();
                rw_ready = 1'b0;
                rw_data_read = {$urandom, $urandom};
                rw_resp = 2'($urandom_range(0, 3));
                if (rw_valid) begin
                    if (!armed) begin
                        armed = 1;
                        r = $urandom_range(0, 15);
                        lat = (r < 12) ? (r % 8) : 100;
                    end
                    if (lat == 0) rw_ready = 1'b1;
                    lat--;
                end else begin
                    armed = 0;
                    if ($urandom_range(0, 9) == 0) rw_ready = 1'b1;
                end
                if (!if_valid && !if_ready && $urandom_range(0, 2) == 0) begin
                    if_valid = 1'b1; if_addr = {$urandom, $urandom};
                    if_size = 2'($urandom_range(0, 3));
                end
                if (!mem_valid && !mem_ready && $urandom_range(0, 2) == 0) begin
                    mem_valid = 1'b1; mem_req = 1'($urandom_range(0, 1));
                    mem_addr = {$urandom, $urandom}; mem_size = 2'($urandom_range(0, 3));
                    mem_data_write = {$urandom, $urandom};
                end
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_axi_arbiter.md
# ysyx_22040759_axi_arbiter

Two-port arbiter that shares the core's single AXI read/write master between the instruction-fetch port (read-only) and the load/store port (read or write). It sits between the CPU top and the AXI bridge. It accepts one outstanding transaction at a time, latches the winner's request, forwards it downstream, and routes the response back to the owning port. A watchdog aborts transactions that the bridge never completes.

## Interface
- TIMEOUT, 1023: cycles a granted transaction may wait for `rw_ready` before it is aborted; legal range 2..65535.
- clock  in  1  single core clock.
- reset  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch request; held until `if_ready`.
- if_addr  in  64  fetch address.
- if_size  in  2  fetch size code.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_data_read  out  64  fetch data; valid while `if_ready`=1.
- if_resp  out  2  fetch response; valid while `if_ready`=1.
- mem_valid  in  1  load/store request; held until `mem_ready`.
- mem_req  in  1  1=write, 0=read.
- mem_addr  in  64  load/store address.
- mem_size  in  2  size code.
- mem_data_write  in  64  store data.
- mem_ready  out  1  one-cycle completion pulse to load/store.
- mem_data_read  out  64  load data; valid while `mem_ready`=1.
- mem_resp  out  2  response; valid while `mem_ready`=1.
- rw_valid  out  1  downstream request; held until `rw_ready` or timeout.
- rw_req, rw_addr, rw_size, rw_data_write  out  1/64/2/64  latched copy of the granted request.
- rw_ready  in  1  downstream one-cycle completion pulse.
- rw_data_read, rw_resp  in  64/2  downstream response; sampled when `rw_ready`=1.

## Operation
- FSM states: IDLE, BUSY, RESP. Registers: `owner` (0=IF, 1=MEM), a request latch, a response latch, `last` (previous owner), and the watchdog counter `wd`.
- IDLE: if any request is valid, select a winner, latch its addr/size/req/wdata (IF latches req=0, wdata=0), set `owner`, clear `wd`, and go to BUSY. Otherwise stay in IDLE.
- Selection with both requests valid: MEM wins (see Configuration). Single request: that port wins.
- BUSY: `rw_valid`=1 with the latched fields; `wd` increments each cycle.
  - `rw_ready`=1: latch `rw_data_read`/`rw_resp` and go to RESP.
  - Else if `wd`==TIMEOUT-1: latch data=0, resp=2'b10 (SLVERR), and go to RESP.
  - `rw_ready` in the same cycle as timeout: the real response wins.
- RESP: pulse `if_ready` or `mem_ready` per `owner` with the latched data/resp; go to IDLE. Non-owner outputs stay 0.
- `rw_resp` is forwarded unmodified, including error codes.
- `rw_ready` in IDLE or RESP (for example, a late response after a timeout) is ignored.
- Request inputs are sampled only in IDLE. Changes while a port is waiting are not tracked.
- Reset mid-transaction: FSM goes to IDLE, all latches clear, `last`=IF, and any in-flight downstream response is dropped.

## Timing
- Reset values: every output is 0; state IDLE; `wd`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Request high in cycle 0 → `rw_valid`=1 from cycle 1.
- `rw_ready` in cycle k → `rw_valid`=0 and `x_ready`=1 in cycle k+1 → IDLE in cycle k+2.
- Earliest next grant: `rw_valid` high in cycle k+3.
- A requester drops valid on the edge after it sees ready, so it is never re-granted twice.
- Timeout: `rw_valid` is high for exactly TIMEOUT cycles, then `x_ready` pulses on the next cycle.
- `wd` width is $clog2(TIMEOUT). It never wraps, because it is cleared on every grant.

## Configuration
- `YSYX_22040759_ARB_RR_EN` defined: round-robin arbitration. When both requests are valid in IDLE, grant the port that is not `last`. `last` updates on each grant.
- Not defined: fixed priority, MEM always beats IF. `last` is still maintained but unused.

## Test plan
- Single fetch: if_valid=1, addr=0x8000_0000; bridge answers rw_ready in cycle 4 with data 0x13, resp 0 → rw_req=0 and rw_addr=0x8000_0000 in cycles 1–4; if_ready=1, if_data_read=0x13 in cycle 5; mem_ready stays 0.
- Store: mem_valid=1, mem_req=1, addr=0x8000_1000, wdata=0xDEAD_BEEF → rw_req=1 and rw_data_write=0xDEAD_BEEF while rw_valid=1; mem_ready pulses exactly once.
- Contention: both ports valid in the same cycle, each served with a 2-cycle bridge latency.
  - Without RR: MEM is granted first, then IF; MEM wins every tie.
  - With RR: grants alternate MEM, IF, MEM, IF.
- Timeout: TIMEOUT=8, rw_ready never asserted → rw_valid high for 8 cycles; then if_ready=1, if_resp=2'b10, data 0; a later rw_ready pulse in IDLE produces no ready.
- Error pass-through: rw_resp=2'b11 with rw_ready → mem_resp=2'b11 on the mem_ready pulse.
- Reset mid-BUSY: assert reset low during BUSY, then release → all outputs 0 immediately; after release a pending if_valid is re-granted from IDLE.
